// File: rtl/sha_mem_responder_if.sv
// Bus bundle for sha_mem_responder: SHA engine memory port, engine control, host load/dump port,
// digest handshake and error reporting.
interface sha_mem_responder_if;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        eng_start;
  logic        eng_done;
  logic [15:0] out_addr;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        hash_valid;
  logic        hash_ack;
  logic        err_clr;
  logic        oor_err;
  logic        proto_err;
  logic        par_err;
  logic        par_inject;

  modport master (
    output mem_we, mem_addr, mem_write_data, eng_start, eng_done, out_addr,
           host_valid, host_we, host_addr, host_wdata, hash_ack, err_clr, par_inject,
    input  mem_read_data, host_ready, host_rvalid, host_rdata, hash_valid,
           oor_err, proto_err, par_err
  );

  modport slave (
    input  mem_we, mem_addr, mem_write_data, eng_start, eng_done, out_addr,
           host_valid, host_we, host_addr, host_wdata, hash_ack, err_clr, par_inject,
    output mem_read_data, host_ready, host_rvalid, host_rdata, hash_valid,
           oor_err, proto_err, par_err
  );
endinterface

// File: rtl/sha_mem_responder.sv
// Word memory shared by the SHA-256 engine and a host load/dump port; tracks digest write-back.
// Optional per-word even parity is enabled by defining SHA_MEM_PARITY_EN.
module sha_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned OUT_WORDS = 8
) (
  input logic           clk,
  input logic           reset_n,
  sha_mem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ENGINE, RESULT} state_t;

  state_t               state, state_next;
  logic [OUT_WORDS-1:0] mask, mask_next, hit_mask;
  logic [15:0]          base, base_next;
  logic                 done_q;
  logic                 done_err;
  logic [31:0]          mem [DEPTH];

  logic          eng_in_range, host_in_range;
  logic [AW-1:0] eng_idx, host_idx;
  logic          eng_wr, host_wr, host_rd, host_accept, ready_c;
  logic          in_win;
  logic [15:0]   offset;
  logic [16:0]   win_end;
  logic          oor_new, proto_new, par_new;

  assign eng_in_range  = 17'(bus.mem_addr)  < 17'(DEPTH);
  assign host_in_range = 17'(bus.host_addr) < 17'(DEPTH);
  assign eng_idx       = AW'(bus.mem_addr);
  assign host_idx      = AW'(bus.host_addr);

  // Host is locked out while the engine owns the memory; a start pulse wins this cycle.
  assign ready_c        = (state != ENGINE) && !bus.eng_start;
  assign bus.host_ready = ready_c;
  assign host_accept    = bus.host_valid && ready_c;
  assign host_wr        = host_accept && bus.host_we && host_in_range;
  assign host_rd        = host_accept && !bus.host_we;
  assign eng_wr         = bus.mem_we && (state == ENGINE) && eng_in_range;

  // Digest window; 17-bit end naturally truncates the window at 0xFFFF.
  assign win_end = 17'(base) + 17'(OUT_WORDS);
  assign in_win  = (17'(bus.mem_addr) >= 17'(base)) && (17'(bus.mem_addr) < win_end);
  assign offset  = bus.mem_addr - base;

  always_comb begin
    hit_mask = '0;
    for (int unsigned i = 0; i < OUT_WORDS; i++) begin
      if (eng_wr && in_win && (offset == 16'(i))) hit_mask[i] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    mask_next  = mask;
    base_next  = base;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.eng_start) begin
          state_next = ENGINE;
          mask_next  = '0;
          base_next  = bus.out_addr;
        end
      end
      ENGINE: begin
        mask_next = mask | hit_mask;
        if (&mask_next) begin
          state_next = RESULT;
        end else if (bus.eng_done && !done_q) begin
          state_next = IDLE;
          done_err   = 1'b1;
        end
      end
      RESULT: begin
        if (bus.eng_start) begin
          state_next = ENGINE;
          mask_next  = '0;
          base_next  = bus.out_addr;
        end else if (bus.hash_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign oor_new   = !eng_in_range || (host_accept && !host_in_range);
  assign proto_new = (bus.mem_we && (state != ENGINE)) || done_err;

`ifdef SHA_MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (eng_wr)       par_mem[eng_idx]  <= (^bus.mem_write_data) ^ bus.par_inject;
    else if (host_wr) par_mem[host_idx] <= (^bus.host_wdata) ^ bus.par_inject;
  end

  assign par_new = (eng_in_range && ((^mem[eng_idx]) != par_mem[eng_idx])) ||
                   (host_rd && host_in_range && ((^mem[host_idx]) != par_mem[host_idx]));
`else
  logic unused_par;
  assign unused_par = bus.par_inject;
  assign par_new    = 1'b0;
`endif

  // Storage is not reset; engine and host never write in the same cycle.
  always_ff @(posedge clk) begin
    if (eng_wr)       mem[eng_idx]  <= bus.mem_write_data;
    else if (host_wr) mem[host_idx] <= bus.host_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      mask              <= '0;
      base              <= '0;
      done_q            <= 1'b0;
      bus.hash_valid    <= 1'b0;
      bus.mem_read_data <= '0;
      bus.host_rvalid   <= 1'b0;
      bus.host_rdata    <= '0;
      bus.oor_err       <= 1'b0;
      bus.proto_err     <= 1'b0;
      bus.par_err       <= 1'b0;
    end else begin
      state             <= state_next;
      mask              <= mask_next;
      base              <= base_next;
      done_q            <= bus.eng_done;
      bus.hash_valid    <= (state_next == RESULT);
      bus.mem_read_data <= eng_in_range ? mem[eng_idx] : '0;
      bus.host_rvalid   <= host_rd;
      if (host_rd) bus.host_rdata <= host_in_range ? mem[host_idx] : '0;
      bus.oor_err       <= (bus.oor_err   && !bus.err_clr) || oor_new;
      bus.proto_err     <= (bus.proto_err && !bus.err_clr) || proto_new;
      bus.par_err       <= (bus.par_err   && !bus.err_clr) || par_new;
    end
  end
endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed self-checking bench for sha_mem_responder (DEPTH=256, OUT_WORDS=8).
module tb_sha_mem_responder;
  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_mem [16];

  sha_mem_responder_if bus ();

  sha_mem_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d, input logic inj);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.par_inject = inj;
    tick();
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.par_inject = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = a;
    tick();
    bus.host_valid = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.host_rvalid), 32'd1);
    check(tag, bus.host_rdata, exp);
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.eng_start      = 1'b0;
    bus.eng_done       = 1'b0;
    bus.out_addr       = '0;
    bus.host_valid     = 1'b0;
    bus.host_we        = 1'b0;
    bus.host_addr      = '0;
    bus.host_wdata     = '0;
    bus.hash_ack       = 1'b0;
    bus.err_clr        = 1'b0;
    bus.par_inject     = 1'b0;

    #12;
    check("rst_hash_valid", 32'(bus.hash_valid), 32'd0);
    check("rst_rvalid",     32'(bus.host_rvalid), 32'd0);
    check("rst_oor",        32'(bus.oor_err), 32'd0);
    check("rst_proto",      32'(bus.proto_err), 32'd0);
    check("rst_par",        32'(bus.par_err), 32'd0);
    check("rst_mem_rdata",  bus.mem_read_data, 32'd0);
    check("rst_host_ready", 32'(bus.host_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Host load and readback
    host_write(16'h0000, 32'h6162_6380, 1'b0);
    exp_mem[0] = 32'h6162_6380;
    host_read("host_rd_addr0", 16'h0000, 32'h6162_6380);
    tick();
    check("rvalid_one_pulse", 32'(bus.host_rvalid), 32'd0);
    for (int i = 1; i < 16; i++) begin
      exp_mem[i] = 32'hA5A5_0000 | 32'(i);
      host_write(16'(i), exp_mem[i], 1'b0);
    end

    // Engine run 1: message reads
    bus.eng_start = 1'b1;
    bus.out_addr  = 16'h0010;
    tick();
    bus.eng_start = 1'b0;
    check("eng_host_ready", 32'(bus.host_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.mem_addr = 16'(i);
      tick();
      check($sformatf("eng_rd_%0d", i), bus.mem_read_data, exp_mem[i]);
    end

    // Digest write-back, 0x10 written twice; read-during-write returns old data
    bus.mem_we         = 1'b1;
    bus.mem_addr       = 16'h0010;
    bus.mem_write_data = 32'hBAD0_0010;
    tick();
    check("hv_after_first", 32'(bus.hash_valid), 32'd0);
    bus.mem_write_data = 32'hD000_0010;
    tick();
    check("rdw_old_data", bus.mem_read_data, 32'hBAD0_0010);
    check("hv_after_repeat", 32'(bus.hash_valid), 32'd0);
    for (int a = 16'h11; a <= 16'h17; a++) begin
      bus.mem_addr       = 16'(a);
      bus.mem_write_data = 32'hD000_0000 | 32'(a);
      tick();
      check($sformatf("hv_after_%0h", a), 32'(bus.hash_valid), (a == 16'h17) ? 32'd1 : 32'd0);
    end
    bus.mem_we   = 1'b0;
    bus.mem_addr = 16'h0000;
    tick();
    check("hv_held", 32'(bus.hash_valid), 32'd1);
    check("result_host_ready", 32'(bus.host_ready), 32'd1);
    bus.hash_ack = 1'b1;
    tick();
    bus.hash_ack = 1'b0;
    check("hv_after_ack", 32'(bus.hash_valid), 32'd0);
    check("proto_clean", 32'(bus.proto_err), 32'd0);
    host_read("digest_0", 16'h0010, 32'hD000_0010);
    host_read("digest_7", 16'h0017, 32'hD000_0017);

    // Engine run 2: host locked out, early done
    bus.eng_start = 1'b1;
    bus.out_addr  = 16'h0020;
    tick();
    bus.eng_start  = 1'b0;
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 16'h0000;
    #1;
    check("lock_ready", 32'(bus.host_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.mem_we         = 1'b1;
      bus.mem_addr       = 16'h0020 + 16'(i);
      bus.mem_write_data = 32'hC000_0000 | 32'(i);
      tick();
      check($sformatf("lock_ready_%0d", i), 32'(bus.host_ready), 32'd0);
      check($sformatf("lock_rvalid_%0d", i), 32'(bus.host_rvalid), 32'd0);
    end
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 16'h0000;
    bus.host_valid = 1'b0;
    bus.eng_done   = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check("early_done_proto", 32'(bus.proto_err), 32'd1);
    check("early_done_hv", 32'(bus.hash_valid), 32'd0);
    check("early_done_idle", 32'(bus.host_ready), 32'd1);

    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("proto_cleared", 32'(bus.proto_err), 32'd0);

    // Engine write while IDLE is dropped
    bus.mem_we         = 1'b1;
    bus.mem_addr       = 16'h0000;
    bus.mem_write_data = 32'hFFFF_FFFF;
    tick();
    bus.mem_we = 1'b0;
    check("idle_we_proto", 32'(bus.proto_err), 32'd1);
    host_read("idle_we_dropped", 16'h0000, 32'h6162_6380);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // Out-of-range host access
    host_write(16'h0100, 32'h0000_DEAD, 1'b0);
    check("oor_write", 32'(bus.oor_err), 32'd1);
    host_read("oor_addr0_kept", 16'h0000, 32'h6162_6380);
    host_read("oor_read_zero", 16'h0100, 32'h0000_0000);
    bus.err_clr = 1'b1;
    host_write(16'h0100, 32'h0000_BEEF, 1'b0);
    check("oor_clr_vs_new", 32'(bus.oor_err), 32'd1);
    tick();
    bus.err_clr = 1'b0;
    check("oor_cleared", 32'(bus.oor_err), 32'd0);

    // Parity injection
    host_write(16'h0005, 32'h1234_5678, 1'b1);
    check("par_before_read", 32'(bus.par_err), 32'd0);
    host_read("par_data_unmod", 16'h0005, 32'h1234_5678);
`ifdef SHA_MEM_PARITY_EN
    check("par_err_set", 32'(bus.par_err), 32'd1);
`else
    check("par_err_tied", 32'(bus.par_err), 32'd0);
`endif
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // eng_start has priority over a pending host request
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = 16'h0001;
    bus.eng_start  = 1'b1;
    bus.out_addr   = 16'h0030;
    #1;
    check("start_blocks_ready", 32'(bus.host_ready), 32'd0);
    tick();
    bus.eng_start  = 1'b0;
    bus.host_valid = 1'b0;
    check("start_no_rvalid", 32'(bus.host_rvalid), 32'd0);

    // Reset mid-run, then a read pending in flight is discarded
    reset_n = 1'b0;
    #1;
    check("midrst_idle", 32'(bus.host_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    bus.host_valid = 1'b1;
    bus.host_addr  = 16'h0002;
    tick();
    bus.host_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_rvalid", 32'(bus.host_rvalid), 32'd0);
    reset_n = 1'b1;
    tick();
    host_read("midrst_storage", 16'h0000, 32'h6162_6380);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
